// File: rtl/pc_sequencer.sv
// Multi-cycle PC/fetch controller: owns the PC, runs the imem handshake, hands each
// instruction to the datapath and picks the next PC once the datapath retires it.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        nextPCSrc,
    input  logic [31:0] alu_res,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        trap,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(FETCH_TIMEOUT - 1);

    // Taken targets drop bit 0 so JALR targets with an odd address stay legal.
    function automatic logic [31:0] next_target(input logic taken, input logic [31:0] alu,
                                                input logic [31:0] seq);
        return taken ? {alu[31:1], 1'b0} : seq;
    endfunction

    state_t      state_p0, state_nxt;
    logic [31:0] pc_p0, pc_nxt;
    logic [31:0] inst_p0, inst_nxt;
    logic [31:0] ret_p0, ret_nxt;
    logic [31:0] tmo_p0, tmo_nxt;
    logic        trap_p0, trap_nxt;
    logic        ferr_p0, ferr_nxt;
    logic [31:0] target;

    assign pc_plus4 = pc_p0 + 32'd4;
    assign target   = next_target(nextPCSrc, alu_res, pc_plus4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= S_FETCH;
            pc_p0    <= RESET_PC;
            inst_p0  <= 32'd0;
            ret_p0   <= 32'd0;
            tmo_p0   <= 32'd0;
            trap_p0  <= 1'b0;
            ferr_p0  <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            inst_p0  <= inst_nxt;
            ret_p0   <= ret_nxt;
            tmo_p0   <= tmo_nxt;
            trap_p0  <= trap_nxt;
            ferr_p0  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        pc_nxt    = pc_p0;
        inst_nxt  = inst_p0;
        ret_nxt   = ret_p0;
        tmo_nxt   = tmo_p0;
        trap_nxt  = trap_p0;
        ferr_nxt  = ferr_p0;
        unique case (state_p0)
            S_FETCH: begin
                if (imem_ack) begin
                    inst_nxt  = imem_rdata;
                    tmo_nxt   = 32'd0;
                    state_nxt = S_EXEC;
                end else if ((FETCH_TIMEOUT != 0) && (tmo_p0 == TMO_LAST)) begin
                    ferr_nxt  = 1'b1;
                    tmo_nxt   = 32'd0;
                    state_nxt = S_FAULT;
                end else begin
                    tmo_nxt = tmo_p0 + 32'd1;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    // Word-misaligned control-flow target: fault without retiring.
                    if (nextPCSrc && target[1]) begin
                        trap_nxt  = 1'b1;
                        state_nxt = S_FAULT;
                    end else begin
                        pc_nxt    = target;
                        ret_nxt   = ret_p0 + 32'd1;
                        state_nxt = halt ? S_HALTED : S_FETCH;
                    end
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_FAULT;
        endcase
    end

    assign imem_req   = (state_p0 == S_FETCH);
    assign imem_addr  = pc_p0;
    assign inst_valid = (state_p0 == S_EXEC);
    assign inst       = inst_p0;
    assign pc         = pc_p0;
    assign retired    = ret_p0;
    assign trap       = trap_p0;
    assign fetch_err  = ferr_p0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus pushes expected fetch addresses
// and retiring instructions; a negedge monitor pops and compares on each handshake.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        exec_done = 1'b0;
    logic        nextPCSrc = 1'b0;
    logic [31:0] alu_res = 32'd0;
    logic        halt = 1'b0;

    logic        req0, vld0, trap0, ferr0;
    logic [31:0] addr0, inst0, pc0, pc4_0, ret0;
    logic        req1, vld1, trap1, ferr1;
    logic [31:0] addr1, inst1, pc1, pc4_1, ret1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0;

    logic [31:0] q_addr[$];
    logic [31:0] q_inst[$];
    logic [31:0] q_pc[$];

    pc_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) u0 (
        .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst0), .inst_valid(vld0), .exec_done(exec_done),
        .nextPCSrc(nextPCSrc), .alu_res(alu_res), .halt(halt), .pc(pc0), .pc_plus4(pc4_0),
        .retired(ret0), .trap(trap0), .fetch_err(ferr0)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(16)) u1 (
        .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst1), .inst_valid(vld1), .exec_done(exec_done),
        .nextPCSrc(nextPCSrc), .alu_res(alu_res), .halt(halt), .pc(pc1), .pc_plus4(pc4_1),
        .retired(ret1), .trap(trap1), .fetch_err(ferr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch and every retiring instruction is scored.
    always @(negedge clk) begin
        if (!rst && req0 && imem_ack) begin
            if (q_addr.size() == 0) chk("fetch_unexpected", addr0, 32'hDEAD_DEAD);
            else chk("fetch_addr", addr0, q_addr.pop_front());
        end
        if (!rst && vld0 && exec_done) begin
            if (q_inst.size() == 0) chk("exec_unexpected", inst0, 32'hDEAD_DEAD);
            else begin
                chk("exec_inst", inst0, q_inst.pop_front());
                chk("exec_pc", pc0, q_pc.pop_front());
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic fetch(input int waits, input logic [31:0] addr, input logic [31:0] data);
        imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(req0), 32'd1);
            chk("wait_addr", addr0, addr);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        q_addr.push_back(addr);
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic exec(input logic src, input logic [31:0] alu, input logic hlt,
                        input logic [31:0] einst, input logic [31:0] epc);
        exec_done = 1'b1;
        nextPCSrc = src;
        alu_res   = alu;
        halt      = hlt;
        q_inst.push_back(einst);
        q_pc.push_back(epc);
        tick();
        exec_done = 1'b0;
        nextPCSrc = 1'b0;
        halt      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset(2);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_req", 32'(req0), 32'd1);
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_inst", inst0, 32'h0);
        chk("rst_retired", ret0, 32'h0);
        chk("rst_trap", 32'(trap0), 32'd0);
        chk("rst_ferr", 32'(ferr0), 32'd0);
        chk("rst_pc_wrapinst", pc1, 32'hFFFF_FFFC);

        // Back-to-back sequential execution, then a taken JALR-style jump.
        c0 = cyc;
        fetch(0, 32'h0, 32'h0000_0013);
        exec(1'b0, 32'h0, 1'b0, 32'h0000_0013, 32'h0);
        chk("wrap_pc", pc1, 32'h0);
        chk("wrap_trap", 32'(trap1), 32'd0);
        chk("pc_plus4", pc4_0, 32'h8);
        fetch(0, 32'h4, 32'h0010_0093);
        exec(1'b0, 32'h0, 1'b0, 32'h0010_0093, 32'h4);
        fetch(0, 32'h8, 32'h1000_0067);
        exec(1'b1, 32'h101, 1'b0, 32'h1000_0067, 32'h8);
        chk("three_in_six", 32'(cyc - c0), 32'd6);
        chk("jalr_pc", pc0, 32'h100);
        chk("jalr_trap", 32'(trap0), 32'd0);
        chk("seq_retired", ret0, 32'd3);

        // Delayed ack, then misaligned taken target.
        fetch(5, 32'h100, 32'hABCD_1234);
        chk("wait_inst", inst0, 32'hABCD_1234);
        chk("wait_valid", 32'(vld0), 32'd1);
        exec(1'b1, 32'h102, 1'b0, 32'hABCD_1234, 32'h100);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fault_req", 32'(req0), 32'd0);
            chk("fault_valid", 32'(vld0), 32'd0);
            tick();
        end
        imem_ack = 1'b0;
        chk("mis_trap", 32'(trap0), 32'd1);
        chk("mis_pc", pc0, 32'h100);
        chk("mis_retired", ret0, 32'd3);

        do_reset(1);
        chk("fault_rst_trap", 32'(trap0), 32'd0);
        chk("fault_rst_pc", pc0, 32'h0);
        chk("fault_rst_ret", ret0, 32'd0);

        // No ack at all: 16 FETCH cycles then fetch_err.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tmo_req", 32'(req0), 32'd1);
            chk("tmo_ferr", 32'(ferr0), 32'd0);
            tick();
        end
        chk("tmo_ferr_set", 32'(ferr0), 32'd1);
        chk("tmo_req_off", 32'(req0), 32'd0);

        do_reset(1);
        chk("tmo_rst_ferr", 32'(ferr0), 32'd0);

        // Ack on the last allowed cycle wins over the timeout.
        fetch(15, 32'h0, 32'h0000_0513);
        chk("late_ack_ferr", 32'(ferr0), 32'd0);
        chk("late_ack_valid", 32'(vld0), 32'd1);
        exec(1'b0, 32'h0, 1'b0, 32'h0000_0513, 32'h0);
        chk("late_pc", pc0, 32'h4);
        chk("late_ret", ret0, 32'd1);

        // Reset collides with exec_done: no retire.
        fetch(0, 32'h4, 32'h0000_0593);
        exec_done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exec_done = 1'b0;
        chk("midrst_pc", pc0, 32'h0);
        chk("midrst_ret", ret0, 32'd0);
        chk("midrst_inst", inst0, 32'h0);
        chk("midrst_req", 32'(req0), 32'd1);

        // Halt after retire; stray handshakes ignored.
        fetch(0, 32'h0, 32'h0010_0073);
        exec(1'b0, 32'h0, 1'b1, 32'h0010_0073, 32'h0);
        chk("halt_pc", pc0, 32'h4);
        chk("halt_ret", ret0, 32'd1);
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(req0), 32'd0);
            chk("halt_valid", 32'(vld0), 32'd0);
            tick();
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        chk("halt_pc_hold", pc0, 32'h4);
        chk("halt_ret_hold", ret0, 32'd1);

        chk("q_addr_empty", 32'(q_addr.size()), 32'd0);
        chk("q_inst_empty", 32'(q_inst.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
